// File: rtl/msdap_pkg.sv
// Shared MSDAP output-stage definitions: word width, default bit-rate divider
// and the serializer state encoding.
package msdap_pkg;

    localparam int unsigned MSDAP_OUT_WIDTH = 40;
    localparam int unsigned MSDAP_CLK_DIV   = 35;

    typedef logic [MSDAP_OUT_WIDTH-1:0] out_word_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_e;

endpackage

// File: rtl/msdap_word_fifo.sv
// Small synchronous FIFO holding left/right word pairs between the core and the serializer.
// The read data is the current head entry, so it is valid whenever the FIFO is not empty.
module msdap_word_fifo #(
    parameter int unsigned DATA_W = 80,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/msdap_out_serializer.sv
// MSDAP output stage: buffers left/right result pairs and shifts them out MSB-first,
// one bit every CLK_DIV sClk cycles, with a shared frame strobe on the first bit.
module msdap_out_serializer
    import msdap_pkg::*;
#(
    parameter int unsigned WIDTH      = MSDAP_OUT_WIDTH,
    parameter int unsigned CLK_DIV    = MSDAP_CLK_DIV,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             sClk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inDataL,
    input  logic [WIDTH-1:0] inDataR,
    output logic             outFrame,
    output logic             outBitL,
    output logic             outBitR,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(WIDTH - 1);

    ser_state_e         state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shift_l;
    logic [WIDTH-1:0]   shift_r;

    logic               push;
    logic               pop;
    logic               last_tick;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    msdap_word_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sClk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({inDataL, inDataR}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Acceptance looks at the occupancy before this edge's pop, so a full FIFO
    // rejects a push even on the cycle its head is being reloaded.
    assign inReady = !fifo_full;

    always_comb begin
        push      = inValid && !fifo_full;
        last_tick = (state == SHIFT) && (div_cnt == DIV_LAST) && (bit_cnt == '0);
        pop       = !fifo_empty && ((state == IDLE) || last_tick);
    end

    // Serial outputs are registered from the shift state, so every pin lags the
    // FSM by one cycle and frame, data and busy stay mutually aligned.
    always_ff @(posedge sClk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shift_l  <= '0;
            shift_r  <= '0;
            outFrame <= 1'b0;
            outBitL  <= 1'b0;
            outBitR  <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            outFrame <= (state == SHIFT) && (bit_cnt == BIT_FIRST);
            outBitL  <= (state == SHIFT) && shift_l[WIDTH-1];
            outBitR  <= (state == SHIFT) && shift_r[WIDTH-1];
            busy     <= (state == SHIFT) || (fifo_count != '0);
            if (inValid && fifo_full) overflow <= 1'b1;

            if (pop) begin
                shift_l <= fifo_head[2*WIDTH-1:WIDTH];
                shift_r <= fifo_head[WIDTH-1:0];
                bit_cnt <= BIT_FIRST;
                div_cnt <= '0;
                state   <= SHIFT;
            end else if (state == SHIFT) begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end else if (bit_cnt != '0) begin
                    shift_l <= {shift_l[WIDTH-2:0], 1'b0};
                    shift_r <= {shift_r[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - BIT_W'(1);
                    div_cnt <= '0;
                end else begin
                    div_cnt <= '0;
                    state   <= IDLE;
                end
            end
        end
    end

endmodule
